gpio_port_controller: RTL

- Bus-mapped 8-bit GPIO controller for the 6502 system: register file, pin direction control, input synchronisation, edge-triggered interrupts.
- Sits between the CPU bus decode (active-low chip select) and the board GPIO header.
- Replaces the write-only output latch with a full read/write port that can raise IRQ.

---
 rtl/gpio_pkg.sv | 19 +
 rtl/gpio_input_sync.sv | 80 ++++++++
 rtl/gpio_port_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port controller: register map, access FSM encoding, port width.
package gpio_pkg;

    localparam int GPIO_W = 8;

    localparam logic [2:0] REG_OUT   = 3'd0;
    localparam logic [2:0] REG_DIR   = 3'd1;
    localparam logic [2:0] REG_IN    = 3'd2;
    localparam logic [2:0] REG_IFLAG = 3'd3;
    localparam logic [2:0] REG_IMASK = 3'd4;
    localparam logic [2:0] REG_EDGE  = 3'd5;
    localparam logic [2:0] REG_SET   = 3'd6;
    localparam logic [2:0] REG_CLR   = 3'd7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/gpio_input_sync.sv
// Pad input path: two-flop synchroniser, optional GPIO_DEBOUNCE_EN qualifier, rise/fall detect.
// Level follows the pad two edges later (plus DEBOUNCE_CYCLES when debounced); no backpressure.
module gpio_input_sync #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("gpio_input_sync: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       prime_q;
    logic             primed;

`ifdef GPIO_DEBOUNCE_EN
    // Extra prime step: the qualifier is loaded straight from the first real s2 sample.
    localparam logic [2:0] PRIME_MAX = 3'd4;
    localparam int         CW        = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] qual_q;
    logic [CW-1:0]    cnt_q [WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qual_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else if (prime_q == PRIME_MAX - 3'd2) begin
            qual_q <= s2_q;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i] == qual_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    qual_q[i] <= s2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign level_o = qual_q;
`else
    localparam logic [2:0] PRIME_MAX = 3'd3;

    assign level_o = s2_q;
`endif

    // Edges stay masked until both level and prev hold post-reset samples,
    // so pins that are static high out of reset never flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            prev_q <= level_o;
            if (prime_q != PRIME_MAX) prime_q <= prime_q + 3'd1;
        end
    end

    assign primed = (prime_q == PRIME_MAX);
    assign rise_o = primed ? (level_o & ~prev_q) : '0;
    assign fall_o = primed ? (~level_o & prev_q) : '0;

endmodule

// File: rtl/gpio_port_controller.sv
// 6502 bus GPIO port: access FSM (one commit per CS-low access), register file, edge IRQ.
// Writes land one cycle after CS rises; reads are combinational; GPIO_DEBOUNCE_EN adds input qualification.
module gpio_port_controller
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_W,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CS,
    input  logic             RW,
    input  logic [2:0]       ADDR,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             DATA_OE,
    input  logic [WIDTH-1:0] PIN_IN,
    output logic [WIDTH-1:0] PIN_OUT,
    output logic [WIDTH-1:0] PIN_DIR,
    output logic             IRQ
);

    logic [1:0]       state_q, state_d;
    logic [2:0]       cap_addr_q, cap_addr_d;
    logic             cap_rw_q, cap_rw_d;
    logic [WIDTH-1:0] cap_data_q, cap_data_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] iflag_q, iflag_d;
    logic [WIDTH-1:0] imask_q, imask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic             irq_q;
    logic [WIDTH-1:0] in_level, in_rise, in_fall, edge_hit, w1c;
    logic             commit, rd_en;

    gpio_input_sync #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync (
        .clk     (CLK),
        .rst_n   (RST),
        .pin_i   (PIN_IN),
        .level_o (in_level),
        .rise_o  (in_rise),
        .fall_o  (in_fall)
    );

    assign commit   = (state_q == ST_COMMIT);
    assign edge_hit = (in_rise & edge_q) | (in_fall & ~edge_q);

    always_comb begin
        state_d    = state_q;
        cap_addr_d = cap_addr_q;
        cap_rw_d   = cap_rw_q;
        cap_data_d = cap_data_q;
        if (!CS) begin
            cap_addr_d = ADDR;
            cap_rw_d   = RW;
            cap_data_d = DATA_IN;
        end
        case (state_q)
            ST_IDLE:   if (!CS) state_d = ST_ACCESS;
            ST_ACCESS: if (CS) state_d = cap_rw_q ? ST_IDLE : ST_COMMIT;
            ST_COMMIT: state_d = CS ? ST_IDLE : ST_ACCESS;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        imask_d = imask_q;
        edge_d  = edge_q;
        w1c     = '0;
        if (commit) begin
            case (cap_addr_q)
                REG_OUT:   out_d   = cap_data_q;
                REG_DIR:   dir_d   = cap_data_q;
                REG_IFLAG: w1c     = cap_data_q;
                REG_IMASK: imask_d = cap_data_q;
                REG_EDGE:  edge_d  = cap_data_q;
                REG_SET:   out_d   = out_q | cap_data_q;
                REG_CLR:   out_d   = out_q & ~cap_data_q;
                default:   ;
            endcase
        end
        // A fresh edge beats a same-cycle clear.
        iflag_d = (iflag_q & ~w1c) | edge_hit;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cap_addr_q <= '0;
            cap_rw_q   <= 1'b1;
            cap_data_q <= '0;
            out_q      <= '0;
            dir_q      <= '0;
            iflag_q    <= '0;
            imask_q    <= '0;
            edge_q     <= '0;
            irq_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cap_addr_q <= cap_addr_d;
            cap_rw_q   <= cap_rw_d;
            cap_data_q <= cap_data_d;
            out_q      <= out_d;
            dir_q      <= dir_d;
            iflag_q    <= iflag_d;
            imask_q    <= imask_d;
            edge_q     <= edge_d;
            irq_q      <= ~|(iflag_q & imask_q);
        end
    end

    assign rd_en = !CS && RW && RST;

    always_comb begin
        DATA_OUT = '0;
        if (rd_en) begin
            case (ADDR)
                REG_OUT, REG_SET, REG_CLR: DATA_OUT = out_q;
                REG_DIR:   DATA_OUT = dir_q;
                REG_IN:    DATA_OUT = in_level;
                REG_IFLAG: DATA_OUT = iflag_q;
                REG_IMASK: DATA_OUT = imask_q;
                REG_EDGE:  DATA_OUT = edge_q;
                default:   DATA_OUT = '0;
            endcase
        end
    end

    assign DATA_OE = rd_en;
    assign PIN_OUT = out_q;
    assign PIN_DIR = dir_q;
    assign IRQ     = irq_q;

endmodule
